div_rv32m_seq: RTL and testbench
================================

Name: div_rv32m_seq

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Counterpart to the combinational multiply path in the M-extension execute stage.
- Takes one request at a time over a start/busy/done handshake and returns one 32-bit result.
- The execute stage stalls on busy.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is verified; the counter width is derived as $clog2(WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  WIDTH  rs1 value; sampled with start
- divisor  in  WIDTH  rs2 value; sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result is valid while it is high
- result  out  WIDTH  quotient or remainder; held until the next accepted start

Behaviour:
- Reset: one clock and reset (clk, rst); reset is synchronous and active-high. On rst: state=IDLE, busy=0, done=0, result=0, counter=0. rst has priority over start.
- Reset mid-operation aborts the operation. No done pulse is produced, and the next start after rst is released is accepted normally.
- States: IDLE, CALC, FIXUP.
- IDLE:
  - When start=1, latch op and the operands.
  - Signed ops: take absolute values and record sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
  - Unsigned ops: signs are 0.
  - Clear the remainder and counter, then go to CALC.
- CALC (exactly WIDTH cycles), one restoring step per cycle:
  - rem = {rem[WIDTH-2:0], q[WIDTH-1]}; q shifted left by 1.
  - If rem >= |divisor|, subtract |divisor| and set q[0]=1.
  - Go to FIXUP after the WIDTH-th step.
- FIXUP (1 cycle):
  - Quotient is negated if sign_q=1 AND divisor!=0. The divisor-zero suppression preserves the all-ones result.
  - Remainder is negated if sign_r=1.
  - result = op[1] ? remainder : quotient.
  - done=1 for one cycle; next state is IDLE.
- Latency: start sampled at edge N gives done high in the cycle after edge N+WIDTH+1 (34 cycles for WIDTH=32).
- busy is low in the done cycle. A start in that cycle is accepted, giving back-to-back operation.
- start while busy is ignored. The operand and op inputs are don't-care while busy.
- Arithmetic results required (per the RISC-V spec):
  - x/0: DIV and DIVU give all ones.
  - x%0: REM and REMU give x.
  - DIV 0x80000000/-1 gives 0x80000000; REM of the same gives 0.
  - The restoring datapath produces these naturally, given the divisor-zero sign suppression above.
- Absolute value of 0x80000000 is 0x80000000, treated as unsigned. The internal remainder is WIDTH+1 bits wide to avoid compare overflow.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, when divisor==0, or when the op is signed with dividend==0x80000000 and divisor==0xFFFFFFFF, the block goes straight to FIXUP with the spec result preloaded. done is then high in the cycle after edge N+1 (2-cycle latency).
- Not defined: all cases take the full WIDTH+2 latency. Results are identical either way.

Decomposition:
- Package div_rv32m_pkg holds:
  - the op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU);
  - the state typedef (IDLE/CALC/FIXUP);
  - the constants ALL_ONES and INT_MIN.
- One natural sub-module, div_step: combinational shift/compare/subtract that takes rem, q and divisor and returns the next rem and q. The top module keeps the FSM, counter and sign fixup.

Test Plan:
- DIV 20 / -3 -> result 0xFFFFFFFA (-6); REM 20 / -3 -> 0x00000002; done exactly 34 cycles after start.
- DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU -> 0x00000001. REM -7 / 2 -> 0xFFFFFFFF (-1).
- Divide by zero, dividend 0x12345678:
  - DIV and DIVU -> 0xFFFFFFFF; REM and REMU -> 0x12345678.
  - Also DIV -5/0 -> 0xFFFFFFFF.
  - Latency is 2 with DIV_EARLY_OUT_EN, 34 without.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0x00000000.
- Second start pulsed at cycle 5 of an operation is ignored: result and latency match the first request only. A start in the done cycle is accepted and completes 34 cycles later.
- rst asserted at CALC cycle 10 -> busy=0, done=0, result=0 the next cycle. No done pulse follows, and a fresh DIVU 100/7 then returns 14.

Source files
------------

// File: rtl/div_rv32m_pkg.sv
// Shared op encodings, FSM state type and constants for the RV32M sequential divider.
package div_rv32m_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    // DIV and REM treat their operands as two's complement.
    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/div_rv32m_seq_if.sv
// Request/response bundle between the execute stage and the sequential divider.
interface div_rv32m_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, dividend, divisor,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor,
        output busy, done, result
    );
endinterface

// File: rtl/div_rv32m_seq_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    // The shifted remainder needs one extra bit so the compare cannot overflow.
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Restore (keep the shifted value) when the trial subtraction would go negative.
    always_comb begin
        rem_sh = {rem, q[WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor};
        if (rem_sh >= {1'b0, divisor}) begin
            rem_next = WIDTH'(diff);
            q_next   = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = WIDTH'(rem_sh);
            q_next   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_rv32m_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the
// iteration and finish in two cycles; results are identical either way.
module div_rv32m_seq
    import div_rv32m_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    div_rv32m_seq_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] rem, rem_nx;
    logic [WIDTH-1:0] q, q_nx;
    logic [WIDTH-1:0] dvsr, dvsr_nx;
    logic             sign_q, sign_q_nx;
    logic             sign_r, sign_r_nx;
    logic             sel_rem, sel_rem_nx;
    logic             busy, busy_nx;
    logic             done, done_nx;
    logic [WIDTH-1:0] result, result_nx;

    logic             op_signed;
    logic             neg_a;
    logic             neg_b;
    logic             div_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand conditioning; |INT_MIN| stays 0x8000_0000 and is used as unsigned.
    assign op_signed = is_signed_op(bus.op);
    assign neg_a     = op_signed & bus.dividend[WIDTH-1];
    assign neg_b     = op_signed & bus.divisor[WIDTH-1];
    assign div_zero  = (bus.divisor == '0);
    assign abs_a     = neg_a ? -bus.dividend : bus.dividend;
    assign abs_b     = neg_b ? -bus.divisor  : bus.divisor;

    // Final sign correction of the magnitudes produced by the iteration.
    assign quo_fix = sign_q ? -q   : q;
    assign rem_fix = sign_r ? -rem : rem;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem),
        .q        (q),
        .divisor  (dvsr),
        .rem_next (step_rem),
        .q_next   (step_q)
    );

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            q       <= '0;
            dvsr    <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            sel_rem <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rem     <= rem_nx;
            q       <= q_nx;
            dvsr    <= dvsr_nx;
            sign_q  <= sign_q_nx;
            sign_r  <= sign_r_nx;
            sel_rem <= sel_rem_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            result  <= result_nx;
        end
    end

    // Next-state and next-output logic for IDLE -> CALC (WIDTH steps) -> FIXUP.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        rem_nx     = rem;
        q_nx       = q;
        dvsr_nx    = dvsr;
        sign_q_nx  = sign_q;
        sign_r_nx  = sign_r;
        sel_rem_nx = sel_rem;
        busy_nx    = busy;
        done_nx    = 1'b0;
        result_nx  = result;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    sel_rem_nx = bus.op[1];
                    // A zero divisor keeps the quotient all-ones regardless of signs.
                    sign_q_nx  = (neg_a ^ neg_b) & ~div_zero;
                    sign_r_nx  = neg_a;
                    dvsr_nx    = abs_b;
                    q_nx       = abs_a;
                    rem_nx     = '0;
                    cnt_nx     = '0;
                    busy_nx    = 1'b1;
                    state_nx   = CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (div_zero) begin
                        q_nx     = WIDTH'(ALL_ONES);
                        rem_nx   = abs_a;
                        state_nx = FIXUP;
                    end else if (op_signed && (bus.dividend == WIDTH'(INT_MIN)) &&
                                 (bus.divisor == WIDTH'(ALL_ONES))) begin
                        q_nx     = WIDTH'(INT_MIN);
                        rem_nx   = '0;
                        state_nx = FIXUP;
                    end
`endif
                end
            end

            CALC: begin
                rem_nx = step_rem;
                q_nx   = step_q;
                cnt_nx = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nx = FIXUP;
                end
            end

            FIXUP: begin
                result_nx = sel_rem ? rem_fix : quo_fix;
                done_nx   = 1'b1;
                busy_nx   = 1'b0;
                state_nx  = IDLE;
            end

            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_div_rv32m_seq.sv
// Scoreboard bench for div_rv32m_seq: directed RV32M corner cases plus random ops.
module tb_div_rv32m_seq;
    import div_rv32m_pkg::*;

    localparam int unsigned W        = 32;
    localparam int unsigned FULL_LAT = W + 2;

    typedef struct {
        logic [31:0] res;
        int unsigned lat;
        int unsigned t0;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    div_rv32m_seq_if #(.WIDTH(W)) bus ();

    div_rv32m_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RISC-V M-extension semantics written directly from the ISA rules.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb_v;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        case (op)
            OP_DIV:  return (b == 0) ? ALL_ONES : 32'(sa / sb_v);
            OP_DIVU: return (b == 0) ? ALL_ONES : a / b;
            OP_REM:  return (b == 0) ? a : 32'(sa % sb_v);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned lat_of(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        bit sgn;
        sgn = (op == OP_DIV) || (op == OP_REM);
        if (b == 0 || (sgn && a == INT_MIN && b == ALL_ONES)) return 2;
`endif
        return FULL_LAT;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Drive one request for a single cycle and record what it must produce.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res = model(op, a, b);
        e.lat = lat_of(op, a, b);
        e.t0  = cyc;
        e.op  = op;
        e.a   = a;
        e.b   = b;
        sb.push_back(e);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.op       = 2'($urandom);
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done;
        end
        if (!seen) chk("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_done();
    endtask

    // Pops the oldest expectation whenever the DUT presents a result.
    task automatic monitor();
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                if (bus.done) begin
                    chk("done_single_cycle", 32'(prev_done), 32'd0);
                    chk("busy_low_in_done", 32'(bus.busy), 32'd0);
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'(bus.done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("result op%0d a=%h b=%h", e.op, e.a, e.b),
                            bus.result, e.res);
                        chk($sformatf("latency op%0d a=%h b=%h", e.op, e.a, e.b),
                            32'(cyc - e.t0), 32'(e.lat));
                    end
                end
                prev_done = bus.done;
            end
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          aborted_done;

        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", bus.result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed ISA cases.
        run(OP_DIV,  32'd20, 32'hFFFF_FFFD);
        run(OP_REM,  32'd20, 32'hFFFF_FFFD);
        run(OP_DIVU, 32'hFFFF_FFFF, 32'd2);
        run(OP_REMU, 32'hFFFF_FFFF, 32'd2);
        run(OP_REM,  32'hFFFF_FFF9, 32'd2);
        run(OP_DIV,  32'h1234_5678, 32'd0);
        run(OP_DIVU, 32'h1234_5678, 32'd0);
        run(OP_REM,  32'h1234_5678, 32'd0);
        run(OP_REMU, 32'h1234_5678, 32'd0);
        run(OP_DIV,  32'hFFFF_FFFB, 32'd0);
        run(OP_DIV,  INT_MIN, ALL_ONES);
        run(OP_REM,  INT_MIN, ALL_ONES);

        // A start pulsed mid-operation must be ignored.
        issue(OP_DIV, 32'd20, 32'hFFFF_FFFD);
        repeat (3) @(negedge clk);
        chk("busy_mid_op", 32'(bus.busy), 32'd1);
        bus.start    = 1'b1;
        bus.op       = OP_DIVU;
        bus.dividend = 32'd5;
        bus.divisor  = 32'd1;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_done();

        // Start in the done cycle is accepted.
        issue(OP_DIVU, 32'd1000, 32'd7);
        wait_done();
        run(OP_REM, 32'd1000, 32'd7);

        // Reset in the middle of CALC aborts without a done pulse.
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", bus.result, 32'd0);
        rst = 1'b0;
        sb.delete();
        aborted_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) aborted_done = 1'b1;
        end
        chk("no_done_after_abort", 32'(aborted_done), 32'd0);
        run(OP_DIVU, 32'd100, 32'd7);

        // Random operations with corner-biased divisors and occasional idle gaps.
        for (int k = 0; k < 150; k++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = ALL_ONES;
                2:       b = 32'($urandom_range(1, 16));
                3: begin
                    a = INT_MIN;
                    b = ALL_ONES;
                end
                4:       b = $urandom >> $urandom_range(1, 31);
                default: b = $urandom;
            endcase
            run(op, a, b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
